// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start, then a single-cycle done pulse.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            // The last partial product lands on this edge; flag it once.
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arith ops,
// an iterative multiplier for MUL, and a result held until consumed.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = $clog2(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   y_q;
    logic               carry_q;
    logic               zero_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [WIDTH-1:0]   y_d;
    logic               carry_d;
    logic               ovf_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    // diff[WIDTH] is the borrow, so carry for SUB is its inverse.
    always_comb begin
        y_d     = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        unique case (sel)
            OP_ADD: begin
                y_d     = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                y_d     = diff[WIDTH-1:0];
                carry_d = ~diff[WIDTH];
                ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  y_d = A & B;
            OP_OR:   y_d = A | B;
            OP_XOR:  y_d = A ^ B;
            OP_NAND: y_d = ~(A & B);
            OP_NOR:  y_d = ~(A | B);
            OP_XNOR: y_d = ~(A ^ B);
            OP_SHL:  y_d = A << B[SW-1:0];
            OP_SHR:  y_d = A >> B[SW-1:0];
            default: y_d = '0;
        endcase
    end

    assign mul_start = (state_q == ST_IDLE) && in_valid && (sel == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (sel == OP_MUL) begin
                            state_q <= ST_BUSY;
                        end else begin
                            y_q         <= y_d;
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            zero_q      <= (y_d == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        y_q         <= mul_prod[WIDTH-1:0];
                        carry_q     <= |mul_prod[2*WIDTH-1:WIDTH];
                        ovf_q       <= 1'b0;
                        zero_q      <= (mul_prod[WIDTH-1:0] == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign Y         = y_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=4, plus one WIDTH=8 multiply.
module tb_alu_seq;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       v;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A, B, sel;
    logic       in_valid, out_ready;
    logic       in_ready, carry, zero, overflow, out_valid;
    logic [3:0] Y;

    logic [7:0] a8, b8, y8;
    logic [3:0] sel8;
    logic       iv8, ordy8, ir8, c8, z8, v8, ov8;

    exp_t sb[$];
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .Y(Y), .carry(carry),
        .zero(zero), .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .sel(sel8),
        .in_valid(iv8), .in_ready(ir8), .Y(y8), .carry(c8),
        .zero(z8), .overflow(v8), .out_valid(ov8), .out_ready(ordy8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mkExp(input logic [7:0] y, input logic c, input logic v, input int lat);
        exp_t e;
        e.y = y; e.c = c; e.v = v; e.z = (y == 8'd0); e.lat = lat;
        return e;
    endfunction

    // Independent arithmetic model; lat counts rising edges after the accepting edge.
    function automatic exp_t refModel(input int w, input int a, input int b, input int op);
        exp_t e;
        int   mask = (1 << w) - 1;
        int   r = 0;
        int   p;
        int   sa = (a >> (w - 1)) & 1;
        int   sbit = (b >> (w - 1)) & 1;
        e.c = 1'b0; e.v = 1'b0; e.lat = 0;
        case (op)
            0: begin
                r = a + b;
                e.c = ((r >> w) & 1) != 0;
                r = r & mask;
                e.v = (sa == sbit) && (((r >> (w - 1)) & 1) != sa);
            end
            1: begin
                r = (a - b) & mask;
                e.c = (a >= b);
                e.v = (sa != sbit) && (((r >> (w - 1)) & 1) != sa);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a & b) & mask;
            6: r = ~(a | b) & mask;
            7: r = ~(a ^ b) & mask;
            8: r = (a << (b & (w - 1))) & mask;
            9: r = a >> (b & (w - 1));
            10: begin
                p = a * b;
                r = p & mask;
                e.c = (p >> w) != 0;
                e.lat = w + 1;
            end
            default: r = 0;
        endcase
        e.y = 8'(r);
        e.z = (r == 0);
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input exp_t e);
        exp_t got;
        int   edges = 0;
        sb.push_back(e);
        @(negedge clk);
        A = a; B = b; sel = op; in_valid = 1'b1;
        checkOutput("inReadyIdle", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = ~a; B = ~b;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("outValidSeen", out_valid, 1);
        got = sb.pop_front();
        checkOutput("Y", Y, got.y);
        checkOutput("carry", carry, got.c);
        checkOutput("zero", zero, got.z);
        checkOutput("overflow", overflow, got.v);
        checkOutput("latency", edges, got.lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("outValidCleared", out_valid, 0);
        checkOutput("inReadyReturn", in_ready, 1);
    endtask

    task automatic applyModel(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        applyStimulus(a, b, op, refModel(4, int'(a), int'(b), int'(op)));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int  edges;
        bit  sawValid;
        rst_n = 1'b0; A = '0; B = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
        a8 = '0; b8 = '0; sel8 = '0; iv8 = 1'b0; ordy8 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstY", Y, 0);
        checkOutput("rstZero", zero, 1);
        checkOutput("rstCarry", carry, 0);
        checkOutput("rstOvf", overflow, 0);
        checkOutput("rstOutValid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("inReadyAfterRst", in_ready, 1);

        applyStimulus(4'd5, 4'd3, 4'd0,  mkExp(8'h8, 1'b0, 1'b1, 0));
        applyStimulus(4'd5, 4'd3, 4'd1,  mkExp(8'h2, 1'b1, 1'b0, 0));
        applyStimulus(4'd3, 4'd5, 4'd1,  mkExp(8'hE, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd2,  mkExp(8'h1, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd3,  mkExp(8'h7, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd4,  mkExp(8'h6, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd5,  mkExp(8'hE, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd6,  mkExp(8'h8, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd7,  mkExp(8'h9, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd1, 4'd8,  mkExp(8'hA, 1'b0, 1'b0, 0));
        applyStimulus(4'd5, 4'd3, 4'd10, mkExp(8'hF, 1'b0, 1'b0, 5));
        applyStimulus(4'd9, 4'd6, 4'd12, mkExp(8'h0, 1'b0, 1'b0, 0));

        applyModel(4'hC, 4'd2, 4'd9);
        applyModel(4'hF, 4'hF, 4'd10);
        applyModel(4'hF, 4'h1, 4'd0);
        applyModel(4'h8, 4'h1, 4'd1);
        applyModel(4'h7, 4'h7, 4'd0);
        applyModel(4'h3, 4'h6, 4'd8);
        applyModel(4'h0, 4'h9, 4'd10);

        // Backpressure: result must hold while the consumer stalls.
        @(negedge clk);
        A = 4'd5; B = 4'd3; sel = 4'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            A = 4'd1; B = 4'd1; in_valid = i[0];
            checkOutput("bpY", Y, 8);
            checkOutput("bpOvf", overflow, 1);
            checkOutput("bpInReady", in_ready, 0);
            checkOutput("bpOutValid", out_valid, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        sawValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("bpNoExtraResult", sawValid, 0);
        checkOutput("bpYKept", Y, 8);

        // Reset in the middle of a multiply.
        @(negedge clk);
        A = 4'd7; B = 4'd3; sel = 4'd10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstY", Y, 0);
        checkOutput("midRstZero", zero, 1);
        checkOutput("midRstCarry", carry, 0);
        checkOutput("midRstOvf", overflow, 0);
        checkOutput("midRstOutValid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midRstInReady", in_ready, 1);
        sawValid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midRstNoStale", sawValid, 0);
        applyModel(4'h6, 4'h5, 4'd10);

        // WIDTH=8 multiply whose low byte wraps to zero.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h10; sel8 = 4'd10; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        edges = 0;
        while (!ov8 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("w8OutValid", ov8, 1);
        checkOutput("w8Y", y8, 8'h00);
        checkOutput("w8Carry", c8, 1);
        checkOutput("w8Zero", z8, 1);
        checkOutput("w8Ovf", v8, 0);
        checkOutput("w8Latency", edges, 9);
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        checkOutput("w8Consumed", ov8, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
